// File: rtl/frame_scheduler.sv
// frame_scheduler: one LED-strip refresh per frame request, GRB pixels
// streamed over valid/ready, then a strip latch gap before the next frame.
// Ports: clk, reset (async, active-low), update_frame, current_led,
//   led_{green,red,blue}_intensity, px_data/px_valid/px_ready, busy,
//   frame_done.
// Optional: define FRAME_SCHED_AUTOREFRESH_EN for a periodic self-refresh.
module frame_scheduler #(
  parameter int MAX_POS        = 16,
  parameter int LATCH_CYCLES   = 3000,
  parameter int REFRESH_CYCLES = 1200000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       update_frame,
  output logic [$clog2(MAX_POS)-1:0] current_led,
  input  logic [7:0]                 led_green_intensity,
  input  logic [7:0]                 led_red_intensity,
  input  logic [7:0]                 led_blue_intensity,
  output logic [23:0]                px_data,
  output logic                       px_valid,
  input  logic                       px_ready,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int LW = $clog2(MAX_POS);
  localparam int CW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [LW-1:0] LAST = LW'(MAX_POS - 1);
  localparam logic [CW-1:0] CMAX = CW'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] led_q, led_d;
  logic [23:0]   px_q, px_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req, start, hs, last_tick;

`ifdef FRAME_SCHED_AUTOREFRESH_EN
  localparam int RW =
    (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] RMAX = RW'(REFRESH_CYCLES - 1);

  logic [RW-1:0] ref_q, ref_d;
  logic          ref_tick;

  // Terminal count behaves exactly like a display-unit request.
  assign ref_tick = (ref_q == RMAX);
  assign req      = update_frame | ref_tick;

  // Period is measured from the most recent frame start.
  always_comb begin
    ref_d = ref_tick ? '0 : ref_q + RW'(1);
    if (start) ref_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ref_q <= '0;
    else        ref_q <= ref_d;
  end
`else
  assign req = update_frame;
`endif

  assign hs        = (state_q == SEND) && px_ready;
  assign last_tick = (cnt_q == CMAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      led_q   <= '0;
      px_q    <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      px_q    <= px_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = FETCH;
          start   = 1'b1;
        end
      end
      FETCH: state_d = SEND;
      SEND: begin
        if (hs) state_d = (led_q == LAST) ? LATCH : FETCH;
      end
      LATCH: begin
        // A request landing on the exit cycle still earns a frame.
        if (last_tick) begin
          if (pend_q | req) begin
            state_d = FETCH;
            start   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    led_d  = led_q;
    px_d   = px_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    // Any number of requests mid-frame collapse into one.
    if (state_q != IDLE && req) pend_d = 1'b1;
    if (start) begin
      led_d  = '0;
      pend_d = 1'b0;
    end
    unique case (state_q)
      FETCH: px_d = {led_green_intensity,
                     led_red_intensity,
                     led_blue_intensity};
      SEND: begin
        if (hs) begin
          led_d = (led_q == LAST) ? '0 : led_q + LW'(1);
          cnt_d = '0;
        end
      end
      LATCH: begin
        if (!last_tick) cnt_d = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    current_led = led_q;
    px_data     = px_q;
    px_valid    = (state_q == SEND);
    busy        = (state_q != IDLE);
    frame_done  = (state_q == LATCH) && last_tick;
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: random stimulus against a frame-level model
// (pixel order, latency, latch gap, request collapsing, reset).
module tb_frame_scheduler;

  localparam int NP  = 16;
  localparam int LAT = 50;
  localparam int LW  = $clog2(NP);

  logic          clk = 1'b0;
  logic          reset;
  logic          update_frame;
  logic [LW-1:0] current_led;
  logic [7:0]    g_in, r_in, b_in;
  logic [23:0]   px_data;
  logic          px_valid, px_ready, busy, frame_done;

  logic [7:0] gt [NP];
  logic [7:0] rt [NP];
  logic [7:0] bt [NP];

  assign g_in = gt[current_led];
  assign r_in = rt[current_led];
  assign b_in = bt[current_led];

  frame_scheduler #(
    .MAX_POS(NP), .LATCH_CYCLES(LAT), .REFRESH_CYCLES(5000)
  ) dut (
    .clk(clk), .reset(reset), .update_frame(update_frame),
    .current_led(current_led),
    .led_green_intensity(g_in),
    .led_red_intensity(r_in),
    .led_blue_intensity(b_in),
    .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc, done_at, first_at, px_idx, frames;
  int hs_total, dn_total, stall_left;
  bit busy_m, pending, stall_prev, prev_valid;
  logic [23:0] prev_data;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    busy_m = 0; pending = 0; done_at = -1; px_idx = 0;
    stall_prev = 0; prev_valid = 0; stall_left = 0;
  endtask

  task automatic randomize_tables();
    for (int i = 0; i < NP; i++) begin
      gt[i] = 8'($urandom); rt[i] = 8'($urandom);
      bt[i] = 8'($urandom);
    end
  endtask

  function automatic logic next_rdy(input bit bp);
    if (!bp) return 1'b1;
    if (stall_left > 0) begin
      stall_left--;
      return 1'b0;
    end
    if ($urandom_range(0, 2) == 0) begin
      stall_left = $urandom_range(0, 19);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic step(input logic upd, input logic rdy);
    bit done_now, busy_nxt;
    update_frame = upd;
    px_ready     = rdy;
    done_now = (done_at == cyc);
    chk("frame_done", 32'(frame_done), 32'(done_now));
    chk("busy", 32'(busy), 32'(busy_m));
    if (frame_done) dn_total++;
    if (!busy_m) begin
      chk("idle_valid", 32'(px_valid), 0);
      chk("idle_led", 32'(current_led), 0);
    end
    if (stall_prev) begin
      chk("stall_valid", 32'(px_valid), 1);
      chk("stall_data", 32'(px_data), 32'(prev_data));
    end
    if (px_valid && !prev_valid && px_idx == 0)
      chk("latency", cyc, first_at);
    if (px_valid && rdy) begin
      if (px_idx >= NP) begin
        chk("extra_px", 32'(px_idx), NP - 1);
      end else begin
        chk("led", 32'(current_led), px_idx);
        chk("px", 32'(px_data),
            32'({gt[px_idx], rt[px_idx], bt[px_idx]}));
      end
      hs_total++;
      px_idx++;
      if (px_idx == NP) done_at = cyc + LAT;
    end
    stall_prev = px_valid && !rdy;
    prev_data  = px_data;
    prev_valid = px_valid;
    busy_nxt = busy_m;
    if (upd) begin
      if (!busy_m) begin
        busy_nxt = 1; px_idx = 0; first_at = cyc + 2; frames++;
      end else begin
        pending = 1;
      end
    end
    if (done_now) begin
      if (pending) begin
        pending = 0; px_idx = 0; first_at = cyc + 2; frames++;
      end else begin
        busy_nxt = 0;
      end
    end
    busy_m = busy_nxt;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_idle(input bit bp, input int maxc);
    int n = 0;
    while ((busy_m || pending) && n < maxc) begin
      step(1'b0, next_rdy(bp));
      n++;
    end
    chk("timeout", 32'(n < maxc), 1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  initial begin
    int h0, d0, f0, n;
    bit lp;
    logic u;
    reset = 1'b0; update_frame = 1'b0; px_ready = 1'b0;
    cyc = 0; frames = 0; hs_total = 0; dn_total = 0;
    first_at = 0; prev_data = '0;
    model_reset();
    randomize_tables();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(px_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_led", 32'(current_led), 0);
    chk("rst_data", 32'(px_data), 0);
    chk("rst_done", 32'(frame_done), 0);
    reset = 1'b1;

    // Idle with no requests.
    repeat (100) step(1'b0, 1'($urandom_range(0, 1)));

    // Single frame, ready tied high.
    h0 = hs_total; d0 = dn_total;
    step(1'b1, 1'b1);
    run_idle(1'b0, 500);
    chk("f1_hs", hs_total - h0, NP);
    chk("f1_done", dn_total - d0, 1);

    // Single frame under random backpressure.
    randomize_tables();
    h0 = hs_total;
    step(1'b1, next_rdy(1'b1));
    run_idle(1'b1, 2000);
    chk("bp_hs", hs_total - h0, NP);

    // Overlapping requests collapse into one follow-up frame.
    randomize_tables();
    h0 = hs_total; d0 = dn_total; f0 = frames; lp = 0; n = 0;
    step(1'b1, 1'b1);
    while ((busy_m || pending) && n < 2000) begin
      u = 1'b0;
      if (frames == f0 + 1 && px_valid &&
          (px_idx == 3 || px_idx == 6 || px_idx == 9))
        u = 1'b1;
      if (frames == f0 + 1 && !lp && done_at - cyc == 10) begin
        u = 1'b1;
        lp = 1;
      end
      step(u, 1'b1);
      n++;
    end
    chk("ov_timeout", 32'(n < 2000), 1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("ov_hs", hs_total - h0, 2 * NP);
    chk("ov_done", dn_total - d0, 2);

    // Asynchronous reset in the middle of a frame.
    step(1'b1, 1'b1);
    n = 0;
    while (px_idx < 7 && n < 200) begin
      step(1'b0, 1'b1);
      n++;
    end
    chk("pre_rst_led", 32'(current_led), 7);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(px_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_led", 32'(current_led), 0);
    chk("mid_rst_data", 32'(px_data), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc++;
    model_reset();
    h0 = hs_total;
    step(1'b1, 1'b1);
    run_idle(1'b0, 500);
    chk("rst_hs", hs_total - h0, NP);

    // No self-started frames in the default build.
    d0 = dn_total;
    repeat (200) step(1'b0, 1'b1);
    chk("quiet_done", dn_total - d0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
